prog_loader: RTL and testbench

Byte-stream program loader for the 12-bit MCU's 256x12 program memory. It receives a framed image from a host-side byte source over a valid/ready handshake, assembles 12-bit instruction words, and writes them into program memory. It holds the MCU core in reset until the image is loaded and its checksum verifies. It sits between the external byte source and the program-memory write port, and drives the MCU core's reset input.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 42 ++++
 rtl/pl_timeout_ctr.sv | 28 ++
 rtl/prog_loader.sv | 188 ++++++++++++++++++
 tb/tb_prog_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StLo,
    StHi,
    StCsum,
    StDone,
    StErr
  } pl_state_t;

  // Default frame start marker
  localparam logic [7:0] PL_SYNC_BYTE = 8'hA5;

  // LEN value meaning "fill the whole memory"
  localparam logic [7:0] LEN_ALL = 8'h00;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-source and program-memory signals of the loader, bundled as one interface.
// master: host/bench side; slave: the loader itself.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 12
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [WORD_W-1:0] pm_wdata;
  logic              mcu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  pm_we,
    input  pm_addr,
    input  pm_wdata,
    input  mcu_hold,
    input  load_done,
    input  load_err
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output pm_we,
    output pm_addr,
    output pm_wdata,
    output mcu_hold,
    output load_done,
    output load_err
  );

endinterface

// File: rtl/pl_timeout_ctr.sv
// Inter-byte timeout counter, used only when PROG_LOADER_TIMEOUT_EN is defined.
// Counts cycles while run is high; any clear or idle period restarts it.
module pl_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;

  logic [CntW-1:0] r_cnt;

  // Cycle counter; saturates at the expiry value until cleared
  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      r_cnt <= '0;
    end else if (!expired) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign expired = run && (r_cnt == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC, LEN, LEN x (LO, HI), CSUM frames,
// writes assembled words to program memory and releases the MCU core from
// reset once the checksum verifies.
// Optional build macro: PROG_LOADER_TIMEOUT_EN adds an inter-byte timeout.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WORD_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = PL_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  // Bits of the word carried in the HI byte
  localparam int unsigned HiW  = WORD_W - 8;
  // Word counter needs one extra bit to hold 2**ADDR_W
  localparam int unsigned CntW = ADDR_W + 1;

  pl_state_t r_state, w_state_d;

  logic [CntW-1:0]   r_words_left;
  logic [7:0]        r_lo;
  logic [7:0]        r_csum;
  logic              r_rx_ready;
  logic              r_pm_we;
  logic [ADDR_W-1:0] r_pm_addr;
  logic [WORD_W-1:0] r_pm_wdata;
  logic              r_mcu_hold;
  logic              r_load_done;
  logic              r_load_err;

  logic w_acc;
  logic w_is_sync;
  logic w_hi_bad;
  logic w_last;
  logic w_write;
  logic w_timeout;

  assign w_acc     = bus.rx_valid && r_rx_ready;
  assign w_is_sync = (bus.rx_data == SYNC_BYTE);
  // HI byte bits above the word width must be zero
  assign w_hi_bad  = ((bus.rx_data >> HiW) != 8'd0);
  assign w_last    = (r_words_left == CntW'(1));

`ifdef PROG_LOADER_TIMEOUT_EN
  logic w_to_run;
  logic w_to_expired;

  assign w_to_run = (r_state == StLen) || (r_state == StLo) ||
                    (r_state == StHi)  || (r_state == StCsum);

  pl_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_acc),
    .run    (w_to_run),
    .expired(w_to_expired)
  );

  assign w_timeout = w_to_expired;
`else
  logic w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = (TIMEOUT_CYC == 0);
  assign w_timeout            = 1'b0;
`endif

  // Next-state decode; state only moves on an accepted byte or a timeout
  always_comb begin
    w_state_d = r_state;
    w_write   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_acc && w_is_sync) w_state_d = StLen;
      end
      StLen: begin
        if (w_acc) w_state_d = StLo;
      end
      StLo: begin
        if (w_acc) w_state_d = StHi;
      end
      StHi: begin
        if (w_acc) begin
          if (w_hi_bad) begin
            w_state_d = StErr;
          end else begin
            w_write   = 1'b1;
            w_state_d = w_last ? StCsum : StLo;
          end
        end
      end
      StCsum: begin
        if (w_acc) w_state_d = (bus.rx_data == r_csum) ? StDone : StErr;
      end
      StDone: begin
        w_state_d = StDone;
      end
      StErr: begin
        if (w_acc && w_is_sync) w_state_d = StLen;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    if (w_timeout && !w_acc) begin
      w_state_d = StErr;
    end
  end

  // State register and registered status outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rx_ready  <= 1'b0;
      r_mcu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rx_ready  <= (w_state_d != StDone);
      r_mcu_hold  <= (w_state_d != StDone);
      r_load_done <= (w_state_d == StDone);
      r_load_err  <= (w_state_d == StErr);
    end
  end

  // Frame datapath: word count, low-byte latch and running checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_words_left <= '0;
      r_lo         <= '0;
      r_csum       <= '0;
    end else if (w_acc) begin
      case (r_state)
        StLen: begin
          r_words_left <= (bus.rx_data == LEN_ALL) ? (CntW'(1) << ADDR_W)
                                                   : CntW'(bus.rx_data);
          r_csum       <= bus.rx_data;
        end
        StLo: begin
          r_lo   <= bus.rx_data;
          r_csum <= r_csum ^ bus.rx_data;
        end
        StHi: begin
          if (!w_hi_bad) begin
            r_csum       <= r_csum ^ bus.rx_data;
            r_words_left <= r_words_left - CntW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write port: one-cycle strobe after HI, address advances after each strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
    end else begin
      r_pm_we <= w_write;
      if (w_write) begin
        r_pm_wdata <= {bus.rx_data[HiW-1:0], r_lo};
      end
      if (w_acc && (r_state == StLen)) begin
        r_pm_addr <= '0;
      end else if (r_pm_we) begin
        r_pm_addr <= r_pm_addr + ADDR_W'(1);
      end
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.pm_we     = r_pm_we;
  assign bus.pm_addr   = r_pm_addr;
  assign bus.pm_wdata  = r_pm_wdata;
  assign bus.mcu_hold  = r_mcu_hold;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized
// streams checked against a frame-level reference parser.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  prog_loader #(
    .ADDR_W     (ADDR_W),
    .WORD_W     (WORD_W),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] stim_q[$];  // bytes accepted since the last reset
  int         exp_q[$];   // expected writes: (addr << 12) | data
  int         act_q[$];   // observed writes
  bit         m_done;
  bit         m_err;
  int         max_gap = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.pm_we === 1'b1) begin
      act_q.push_back((int'(bus.pm_addr) << 12) | int'(bus.pm_wdata));
    end
  end

  // Frame-level reference: scan the accepted byte stream for frames
  task automatic model_run();
    int         i;
    int         n;
    int         words;
    logic [7:0] cs;
    logic [7:0] lo;
    logic [7:0] hi;
    n = stim_q.size();
    i = 0;
    exp_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    while (i < n && !m_done) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) break;
      cs    = stim_q[i];
      words = (stim_q[i] == 8'h00) ? 256 : int'(stim_q[i]);
      i++;
      m_err = 1'b0;
      for (int w = 0; w < words && !m_err; w++) begin
        if (i + 1 >= n) return;
        lo = stim_q[i];
        hi = stim_q[i+1];
        i += 2;
        if (hi[7:4] != 4'h0) begin
          m_err = 1'b1;
        end else begin
          cs ^= lo ^ hi;
          exp_q.push_back((w << 12) | int'({hi[3:0], lo}));
        end
      end
      if (m_err) continue;
      if (i >= n) break;
      if (stim_q[i] == cs) m_done = 1'b1;
      else m_err = 1'b1;
      i++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    int gap;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      check_eq("rx_ready_wait", 0, 1);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    stim_q.push_back(b);
    gap = $urandom_range(max_gap, 0);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // fault: 0 none, 1 bad checksum, 2 nonzero HI upper bits at bad_word
  task automatic send_frame(input logic [7:0] len_byte, input bit use_index,
                            input int fault, input int bad_word);
    int          words;
    logic [11:0] word;
    logic [7:0]  cs;
    logic [7:0]  lo;
    logic [7:0]  hi;
    words = (len_byte == 8'h00) ? 256 : int'(len_byte);
    send_byte(8'hA5);
    send_byte(len_byte);
    cs = len_byte;
    for (int w = 0; w < words; w++) begin
      word = use_index ? 12'(w) : 12'($urandom);
      lo   = word[7:0];
      if (!use_index && $urandom_range(3, 0) == 0) lo = 8'hA5;
      hi = {4'h0, word[11:8]};
      if (fault == 2 && w == bad_word) begin
        hi[7:4] = 4'($urandom_range(15, 1));
        send_byte(lo);
        send_byte(hi);
        return;
      end
      cs ^= lo ^ hi;
      send_byte(lo);
      send_byte(hi);
    end
    if (fault == 1) cs ^= 8'($urandom_range(255, 1));
    send_byte(cs);
  endtask

  task automatic send_t1_frame(input logic [7:0] csum);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h0F);
    send_byte(csum);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy"},   int'(bus.rx_ready), 0);
    check_eq({tag, "_we"},    int'(bus.pm_we), 0);
    check_eq({tag, "_addr"},  int'(bus.pm_addr), 0);
    check_eq({tag, "_wdata"}, int'(bus.pm_wdata), 0);
    check_eq({tag, "_hold"},  int'(bus.mcu_hold), 1);
    check_eq({tag, "_done"},  int'(bus.load_done), 0);
    check_eq({tag, "_err"},   int'(bus.load_err), 0);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stim_q.delete();
    act_q.delete();
  endtask

  task automatic check_result(input string tag);
    int nd;
    model_run();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    nd = m_done ? 1 : 0;
    check_eq({tag, "_nwr"}, act_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      check_eq($sformatf("%s_wr%0d", tag, k), act_q[k], exp_q[k]);
    end
    check_eq({tag, "_done"}, int'(bus.load_done), nd);
    check_eq({tag, "_err"},  int'(bus.load_err), m_err ? 1 : 0);
    check_eq({tag, "_hold"}, int'(bus.mcu_hold), 1 - nd);
    check_eq({tag, "_rdy"},  int'(bus.rx_ready), 1 - nd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] junk;
    int         nb;
    int         words;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");

    // 1: basic two-word frame, one byte per cycle, with write timing
    do_reset();
    max_gap = 0;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h01);
    check_eq("t1_we0",    int'(bus.pm_we), 1);
    check_eq("t1_addr0",  int'(bus.pm_addr), 0);
    check_eq("t1_data0",  int'(bus.pm_wdata), 'h134);
    send_byte(8'h78);
    check_eq("t1_we_off", int'(bus.pm_we), 0);
    check_eq("t1_addr_inc", int'(bus.pm_addr), 1);
    send_byte(8'h0F);
    check_eq("t1_we1",    int'(bus.pm_we), 1);
    check_eq("t1_data1",  int'(bus.pm_wdata), 'hF78);
    check_eq("t1_hold_pre", int'(bus.mcu_hold), 1);
    send_byte(8'h40);
    check_eq("t1_hold_post", int'(bus.mcu_hold), 0);
    check_eq("t1_done_post", int'(bus.load_done), 1);
    check_result("t1");
    if (act_q.size() >= 2) begin
      check_eq("t1_w0", act_q[0], 'h00134);
      check_eq("t1_w1", act_q[1], 'h01F78);
    end

    // 2: leading junk before the frame
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_t1_frame(8'h40);
    check_result("t2");

    // 3: bad checksum, then a good frame clears the error
    do_reset();
    send_t1_frame(8'h41);
    check_eq("t3_err",  int'(bus.load_err), 1);
    check_eq("t3_hold", int'(bus.mcu_hold), 1);
    check_eq("t3_nwr",  act_q.size(), 2);
    send_t1_frame(8'h40);
    check_result("t3");

    // 4: bad HI byte in word 0
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h1F);
    check_eq("t4_we", int'(bus.pm_we), 0);
    check_result("t4");

    // 5: LEN=0 fills all 256 words with their index
    do_reset();
    send_frame(8'h00, 1'b1, 0, 0);
    check_result("t5");
    check_eq("t5_cnt",  act_q.size(), 256);
    check_eq("t5_wrap", int'(bus.pm_addr), 0);

    // 6: rst mid-frame, coinciding with an offered HI byte
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h01;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check_reset_vals("t6_rst");
    @(negedge clk);
    check_eq("t6_nowr", act_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stim_q.delete();
    act_q.delete();
    send_t1_frame(8'h40);
    check_result("t6");

    // Stall in LO: error only when the timeout is built in
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (1100) @(posedge clk);
    #1;
`ifdef PROG_LOADER_TIMEOUT_EN
    check_eq("to_err",  int'(bus.load_err), 1);
    check_eq("to_hold", int'(bus.mcu_hold), 1);
`else
    check_eq("to_noerr", int'(bus.load_err), 0);
    send_byte(8'h34);
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h0F);
    send_byte(8'h40);
    check_result("to");
`endif

    // Randomized streams: junk, faulty frames, then usually a good one
    max_gap = 2;
    for (int t = 0; t < 12; t++) begin
      do_reset();
      nb = $urandom_range(3, 0);
      for (int j = 0; j < nb; j++) begin
        do junk = 8'($urandom); while (junk == 8'hA5);
        send_byte(junk);
      end
      nb = $urandom_range(2, 0);
      for (int j = 0; j < nb; j++) begin
        words = $urandom_range(6, 1);
        send_frame(8'(words), 1'b0, $urandom_range(2, 1), $urandom_range(words - 1, 0));
      end
      words = $urandom_range(8, 1);
      if ($urandom_range(3, 0) == 0) begin
        send_frame(8'(words), 1'b0, $urandom_range(2, 1), $urandom_range(words - 1, 0));
      end else begin
        send_frame(8'(words), 1'b0, 0, 0);
      end
      check_result($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
